restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is rstN, asynchronous and active-low.
REQ-002 Port list:
- clk, input, 1, rising-edge clock
- rstN, input, 1, async active-low reset
- dividend, input, 8, signed two's-complement dividend
- divisor, input, 4, signed two's-complement divisor
- start, input, 1, request pulse; operands sampled on the same edge
- quo, output, 8, signed quotient
- rem, output, 4, signed remainder
- busy, output, 1, high while a division is in progress
- done, output, 1, result valid; held until next accepted start
- dz, output, 1, divide-by-zero flag, valid with done
- ovf, output, 1, quotient-overflow flag, valid with done

Function
REQ-003 The FSM SHALL have states IDLE, CALC, FIX, DONE; busy=1 exactly in CALC and FIX.
REQ-004 start=1 in IDLE or DONE SHALL be accepted; start in CALC or FIX SHALL be ignored, with no effect on the operation in progress.
REQ-005 On accept, the block SHALL capture |dividend| (9-bit unsigned), |divisor| (5-bit unsigned) and both sign bits, clear done/dz/ovf, load an iteration count of 8, and enter CALC.
REQ-006 Exception: on accept with divisor=0, the block SHALL enter DONE on the next edge with quo=0, rem=0, dz=1, ovf=0, skipping CALC.
REQ-007 CALC SHALL perform one restoring step per cycle, MSB first, for exactly 8 cycles:
- shift partial remainder left, bringing in the next dividend bit
- trial-subtract |divisor|
- if non-negative: keep the difference and set quotient bit to 1
- otherwise: restore and set quotient bit to 0
REQ-008 FIX SHALL last one cycle, apply the signs, register quo/rem, and enter DONE with done=1.
REQ-009 Latency: accept at edge 0 SHALL give done=1 after edge 9 (edges 1-8 CALC, edge 9 FIX).
REQ-010 Sign rules (truncation toward zero):
- quo negative iff operand signs differ
- rem takes the sign of the dividend
- |rem| < |divisor|
- dividend = quo*divisor + rem whenever ovf=0
REQ-011 dividend=-128 with divisor=-1 SHALL give quo=8'h80, rem=0, ovf=1; ovf SHALL be 0 in all other cases.
REQ-012 divisor=-8 (magnitude 8) and dividend=-128 (magnitude 128) SHALL be handled exactly via the widened internal magnitudes.
REQ-013 quo, rem, dz and ovf SHALL hold their values from the DONE entry until the next accept.
REQ-014 Accepting start in DONE SHALL drop done on the accepting edge and begin the new operation with no idle cycle.
REQ-015 Operand inputs SHALL be don't-care except on the accepting edge.

Reset
REQ-016 rstN=0 SHALL, asynchronously and regardless of state, force:
- state=IDLE
- quo=0, rem=0
- busy=0, done=0, dz=0, ovf=0
- all internal registers cleared
REQ-017 Reset asserted mid-CALC or mid-FIX SHALL abort the operation; no partial result SHALL appear.
REQ-018 After rstN deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-019 -35 / 5, start pulse -> done after 9 edges, quo=-7, rem=0, dz=0, ovf=0; busy high for exactly 9 cycles.
REQ-020 20/3 -> quo=6, rem=2; -20/3 -> quo=-6, rem=-2; 20/-3 -> quo=-6, rem=2.
REQ-021 127 / -8 -> quo=-15, rem=7; -128 / 7 -> quo=-18, rem=-2.
REQ-022 -128 / -1 -> quo=8'h80, rem=0, ovf=1; then 5 / 0 -> done one edge after accept, quo=0, rem=0, dz=1, ovf=0.
REQ-023 Back-to-back ops and reset:
- start held high through a whole op -> second op accepted only from DONE; result of the first is observable for exactly one cycle
- rstN pulsed low in CALC cycle 4 -> all outputs 0 immediately
- a subsequent 20/3 -> quo=6, rem=2

Source files
------------

// File: rtl/restoring_divider.sv
// Signed 8-bit / 4-bit restoring divider: one quotient bit per cycle on magnitudes,
// signs applied in a final fix-up cycle. Quotient truncates toward zero.
module restoring_divider (
   input  logic       clk,
   input  logic       rstN,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   input  logic       start,
   output logic [7:0] quo,
   output logic [3:0] rem,
   output logic       busy,
   output logic       done,
   output logic       dz,
   output logic       ovf
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [8:0] sh_q, sh_d;      // dividend bits shift out the top, quotient bits shift in
   logic [4:0] dvs_q, dvs_d;
   logic [3:0] pr_q, pr_d;
   logic       sgn_a_q, sgn_a_d;
   logic       sgn_b_q, sgn_b_d;
   logic [7:0] quo_q, quo_d;
   logic [3:0] rem_q, rem_d;
   logic       dz_q, dz_d;
   logic       ovf_q, ovf_d;

   logic [8:0] dvd_ext, dvd_mag;
   logic [4:0] dvs_ext, dvs_mag;
   logic [4:0] shifted;
   logic [5:0] trial;
   logic [7:0] q_mag;
   logic       q_neg;

   // NOTE: every variable gets a default at the top of the block so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      dvs_d   = dvs_q;
      pr_d    = pr_q;
      sgn_a_d = sgn_a_q;
      sgn_b_d = sgn_b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;

      // Widened magnitudes so that -128 and -8 are representable unsigned.
      dvd_ext = {dividend[7], dividend};
      dvd_mag = dividend[7] ? (~dvd_ext + 9'd1) : dvd_ext;
      dvs_ext = {divisor[3], divisor};
      dvs_mag = divisor[3] ? (~dvs_ext + 5'd1) : dvs_ext;

      shifted = {pr_q, sh_q[7]};
      trial   = {1'b0, shifted} - {1'b0, dvs_q};
      q_mag   = 8'(sh_q);
      q_neg   = sgn_a_q ^ sgn_b_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               sh_d    = dvd_mag;
               dvs_d   = dvs_mag;
               pr_d    = '0;
               sgn_a_d = dividend[7];
               sgn_b_d = divisor[3];
               cnt_d   = 4'd8;
               quo_d   = '0;
               rem_d   = '0;
               dz_d    = 1'b0;
               ovf_d   = 1'b0;
               if (divisor == 4'd0) begin
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (!trial[5]) begin
               pr_d = 4'(trial);
               sh_d = {sh_q[7:0], 1'b1};
            end else begin
               pr_d = 4'(shifted);
               sh_d = {sh_q[7:0], 1'b0};
            end
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = FIX;
         end
         FIX: begin
            quo_d   = q_neg ? (~q_mag + 8'd1) : q_mag;
            rem_d   = sgn_a_q ? (~pr_q + 4'd1) : pr_q;
            // A positive quotient of magnitude 128 only arises from -128 / -1.
            ovf_d   = ~q_neg & q_mag[7];
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         dvs_q   <= '0;
         pr_q    <= '0;
         sgn_a_q <= 1'b0;
         sgn_b_q <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         dvs_q   <= dvs_d;
         pr_q    <= pr_d;
         sgn_a_q <= sgn_a_d;
         sgn_b_q <= sgn_b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign quo  = quo_q;
   assign rem  = rem_q;
   assign dz   = dz_q;
   assign ovf  = ovf_q;
   assign busy = (state_q == CALC) || (state_q == FIX);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: transaction-level arithmetic model checked every cycle,
// plus directed operations with hand-computed quotient/remainder values.
module tb_restoring_divider;

   logic       clk = 1'b0;
   logic       rstN;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       start;
   logic [7:0] quo;
   logic [3:0] rem;
   logic       busy, done, dz, ovf;

   int n_checks = 0;
   int n_errors = 0;

   restoring_divider dut (
      .clk(clk), .rstN(rstN), .dividend(dividend), .divisor(divisor), .start(start),
      .quo(quo), .rem(rem), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
      logic       o;
   } res_t;

   // Reference result straight from integer arithmetic (truncation toward zero).
   function automatic res_t model_div(input logic [7:0] a, input logic [3:0] b);
      res_t res;
      int   sa, sb;
      sa  = int'(signed'(a));
      sb  = int'(signed'(b));
      res = '0;
      if (sb == 0) begin
         res.z = 1'b1;
      end else if (sa == -128 && sb == -1) begin
         res.q = 8'h80;
         res.o = 1'b1;
      end else begin
         res.q = 8'(sa / sb);
         res.r = 4'(sa % sb);
      end
      return res;
   endfunction

   // Timing model: accept in idle/done, busy 9 cycles, zero divisor completes immediately.
   int   m_left;
   logic m_done;
   res_t m_res, p_res;

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
         p_res  <= '0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_res  <= p_res;
         end
      end else if (start) begin
         p_res <= model_div(dividend, divisor);
         if (divisor == 4'd0) begin
            m_done <= 1'b1;
            m_res  <= model_div(dividend, divisor);
         end else begin
            m_done <= 1'b0;
            m_res  <= '0;
            m_left <= 9;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc busy", 32'(busy), 32'(m_left > 0));
      check("cyc done", 32'(done), 32'(m_done));
      check("cyc dz",   32'(dz),   32'(m_res.z));
      check("cyc ovf",  32'(ovf),  32'(m_res.o));
      if (!(m_left > 0)) begin
         check("cyc quo", 32'(quo), 32'(m_res.q));
         check("cyc rem", 32'(rem), 32'(m_res.r));
      end
   end

   task automatic wait_done(output int lat, output int nbusy);
      lat   = 1;
      nbusy = 0;
      while (!done && lat < 40) begin
         nbusy += int'(busy);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic ez, input logic eo, input int elat);
      int lat, nbusy;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      wait_done(lat, nbusy);
      check({tag, " latency"},     32'(lat),   32'(elat));
      check({tag, " busy cycles"}, 32'(nbusy), 32'(elat - 1));
      check({tag, " quo"}, 32'(quo), 32'(eq));
      check({tag, " rem"}, 32'(rem), 32'(er));
      check({tag, " dz"},  32'(dz),  32'(ez));
      check({tag, " ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      check({tag, " quo hold"}, 32'(quo), 32'(eq));
      check({tag, " done hold"}, 32'(done), 32'(1));
   endtask

   initial begin
      int lat, nbusy;
      rstN     = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #1 rstN  = 1'b0;
      #1;
      check("reset quo",  32'(quo),  32'(0));
      check("reset rem",  32'(rem),  32'(0));
      check("reset busy", 32'(busy), 32'(0));
      check("reset done", 32'(done), 32'(0));
      check("reset dz",   32'(dz),   32'(0));
      check("reset ovf",  32'(ovf),  32'(0));
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      run_op("-35/5",    8'hDD, 4'h5, 8'hF9, 4'h0, 1'b0, 1'b0, 10);
      run_op("20/3",     8'h14, 4'h3, 8'h06, 4'h2, 1'b0, 1'b0, 10);
      run_op("-20/3",    8'hEC, 4'h3, 8'hFA, 4'hE, 1'b0, 1'b0, 10);
      run_op("20/-3",    8'h14, 4'hD, 8'hFA, 4'h2, 1'b0, 1'b0, 10);
      run_op("127/-8",   8'h7F, 4'h8, 8'hF1, 4'h7, 1'b0, 1'b0, 10);
      run_op("-128/7",   8'h80, 4'h7, 8'hEE, 4'hE, 1'b0, 1'b0, 10);
      run_op("-128/-1",  8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 10);
      run_op("5/0",      8'h05, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 1);
      run_op("-128/-8",  8'h80, 4'h8, 8'h10, 4'h0, 1'b0, 1'b0, 10);
      run_op("-128/1",   8'h80, 4'h1, 8'h80, 4'h0, 1'b0, 1'b0, 10);

      // start held high: second op is taken only from DONE, first result shows for one cycle.
      @(negedge clk);
      dividend = 8'h14;
      divisor  = 4'h3;
      start    = 1'b1;
      @(negedge clk);
      dividend = 8'hEC;
      wait_done(lat, nbusy);
      check("b2b first latency", 32'(lat), 32'(10));
      check("b2b first quo", 32'(quo), 32'(8'h06));
      check("b2b first rem", 32'(rem), 32'(4'h2));
      @(negedge clk);
      start = 1'b0;
      check("b2b done one cycle", 32'(done), 32'(0));
      check("b2b second busy",    32'(busy), 32'(1));
      wait_done(lat, nbusy);
      check("b2b second latency", 32'(lat), 32'(10));
      check("b2b second quo", 32'(quo), 32'(8'hFA));
      check("b2b second rem", 32'(rem), 32'(4'hE));

      // Reset during CALC cycle 4 aborts the op with every output cleared at once.
      @(negedge clk);
      dividend = 8'h14;
      divisor  = 4'h3;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-abort busy", 32'(busy), 32'(1));
      #2 rstN = 1'b0;
      #1;
      check("abort quo",  32'(quo),  32'(0));
      check("abort rem",  32'(rem),  32'(0));
      check("abort busy", 32'(busy), 32'(0));
      check("abort done", 32'(done), 32'(0));
      check("abort dz",   32'(dz),   32'(0));
      check("abort ovf",  32'(ovf),  32'(0));
      @(negedge clk);
      rstN = 1'b1;
      run_op("post-reset 20/3", 8'h14, 4'h3, 8'h06, 4'h2, 1'b0, 1'b0, 10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
